// File: rtl/alu_operaciones_pipe.sv
// alu_operaciones_pipe: two-stage valid/ready pipelined two's-complement ALU with ovf/zero/neg/err flags.
// Build option: define ALU_SAT_EN to saturate overflowing results instead of wrapping modulo 2^W.
module alu_operaciones_pipe #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         zero,
  output logic         neg,
  output logic         err
);

  localparam logic [2:0] OP_NEG  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_ABS  = 3'b101;
  localparam logic [2:0] OP_PASS = 3'b110;

  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  // A W+1-bit sum overflowed W bits when its two top bits disagree.
  function automatic logic f_wide_ovf(input logic [W:0] x);
    return x[W] ^ x[W-1];
  endfunction

`ifdef ALU_SAT_EN
  // Every overflow case wraps to the opposite sign, so the wrapped MSB picks the clamp rail.
  function automatic logic [W-1:0] f_finalise(input logic [W-1:0] raw, input logic ovf_in);
    logic [W-1:0] res;
    if (ovf_in) begin
      res = raw[W-1] ? MAX_VAL : MIN_VAL;
    end else begin
      res = raw;
    end
    return res;
  endfunction
`else
  function automatic logic [W-1:0] f_finalise(input logic [W-1:0] raw, input logic ovf_in);
    logic [W-1:0] res;
    if (ovf_in) begin
      res = raw;
    end else begin
      res = raw;
    end
    return res;
  endfunction
`endif

  logic         r_s1_valid;
  logic [2:0]   r_s1_op;
  logic [W-1:0] r_s1_a;
  logic [W-1:0] r_s1_b;

  logic         r_s2_valid;
  logic [W-1:0] r_result;
  logic         r_ovf;
  logic         r_zero;
  logic         r_neg;
  logic         r_err;

  logic         w_s2_load;
  logic         w_in_ready;
  logic [W:0]   w_a_ext;
  logic [W:0]   w_b_ext;
  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W-1:0] w_negb;
  logic         w_b_is_min;
  logic [W-1:0] w_raw;
  logic         w_ovf;
  logic         w_err;
  logic [W-1:0] w_res;

  // Handshake: stage 2 refills when empty or draining, stage 1 follows it.
  always_comb begin
    w_s2_load  = !r_s2_valid || out_ready;
    w_in_ready = !r_s1_valid || w_s2_load;
  end

  // Stage 1 register: operands and opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= 3'b000;
      r_s1_a     <= {W{1'b0}};
      r_s1_b     <= {W{1'b0}};
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_op <= op;
        r_s1_a  <= a;
        r_s1_b  <= b;
      end
    end
  end

  // Stage 2 datapath: wide arithmetic, opcode select and overflow detection.
  always_comb begin
    w_a_ext    = {r_s1_a[W-1], r_s1_a};
    w_b_ext    = {r_s1_b[W-1], r_s1_b};
    w_sum      = w_a_ext + w_b_ext;
    w_diff     = w_a_ext - w_b_ext;
    w_negb     = {W{1'b0}} - r_s1_b;
    w_b_is_min = (r_s1_b == MIN_VAL);
    w_raw      = {W{1'b0}};
    w_ovf      = 1'b0;
    w_err      = 1'b0;
    case (r_s1_op)
      OP_NEG: begin
        w_raw = w_negb;
        w_ovf = w_b_is_min;
      end
      OP_ADD: begin
        w_raw = w_sum[W-1:0];
        w_ovf = f_wide_ovf(w_sum);
      end
      OP_SUB: begin
        w_raw = w_diff[W-1:0];
        w_ovf = f_wide_ovf(w_diff);
      end
      OP_AND: begin
        w_raw = r_s1_a & r_s1_b;
      end
      OP_XOR: begin
        w_raw = r_s1_a ^ r_s1_b;
      end
      OP_ABS: begin
        if (r_s1_b[W-1]) begin
          w_raw = w_negb;
        end else begin
          w_raw = r_s1_b;
        end
        w_ovf = w_b_is_min;
      end
      OP_PASS: begin
        w_raw = r_s1_a;
      end
      default: begin
        w_raw = {W{1'b0}};
        w_err = 1'b1;
      end
    endcase
    w_res = f_finalise(w_raw, w_ovf);
  end

  // Stage 2 register: result and flags, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= {W{1'b0}};
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_ovf    <= w_ovf;
        r_zero   <= (w_res == {W{1'b0}});
        r_neg    <= w_res[W-1];
        r_err    <= w_err;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign neg       = r_neg;
  assign err       = r_err;

endmodule
